axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-master to one-slave arbiter for the AXI-lite read path (AR + R channels) of the shared instruction/data SRAM.
- Master 0 is the IFU instruction fetch; master 1 is the LSU load path. The slave is the AXI SRAM.
- Single outstanding transaction. The grant is held from AR acceptance until the R beat completes, so read data is routed back to the requester that owns it.

Parameters:
- DATA_LEN, 32, address and data width.
- RESP_LEN, 3, rresp width (codebase convention).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- m0_arvalid  input  1  IFU read-address valid
- m0_arready  output  1  IFU read-address ready
- m0_araddr  input  DATA_LEN  IFU read address
- m0_rvalid  output  1  IFU read-data valid
- m0_rready  input  1  IFU read-data ready
- m0_rdata  output  DATA_LEN  IFU read data
- m0_rresp  output  RESP_LEN  IFU read response
- m1_arvalid, m1_arready, m1_araddr, m1_rvalid, m1_rready, m1_rdata, m1_rresp: same directions and widths as the m0 ports, for the LSU
- s_arvalid  output  1  to SRAM
- s_arready  input  1  from SRAM
- s_araddr  output  DATA_LEN  to SRAM
- s_rvalid  input  1  from SRAM
- s_rready  output  1  to SRAM
- s_rdata  input  DATA_LEN  from SRAM
- s_rresp  input  RESP_LEN  from SRAM

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset state: state=IDLE, grant=0, last_grant=1.
  - All valid/ready outputs are 0. s_araddr=0.
  - m0_rdata and m1_rdata are combinational copies of s_rdata. m0_rresp and m1_rresp are copies of s_rresp.
- States: IDLE=2'b00, ADDR=2'b01, DATA=2'b11. Encoding 2'b10 is illegal and returns to IDLE with reset values.
- IDLE:
  - All readies/valids out are 0.
  - If any mN_arvalid=1, latch grant per the arbitration rule and go to ADDR the next cycle. This is a 1-cycle arbitration bubble.
- ADDR:
  - s_arvalid = m[grant]_arvalid and s_araddr = m[grant]_araddr (combinational mux).
  - m[grant]_arready = s_arready. The non-granted master's arready is 0.
  - On s_arvalid & s_arready:
    - If s_rvalid & m[grant]_rready in the same cycle, the transfer completes and the block goes to IDLE.
    - Otherwise go to DATA.
  - If m[grant]_arvalid drops without a handshake, return to IDLE; no slave transfer occurs.
- DATA:
  - m[grant]_rvalid = s_rvalid and s_rready = m[grant]_rready.
  - The non-granted master's rvalid is 0.
  - On s_rvalid & s_rready: update last_grant := grant and go to IDLE.
- R-channel routing applies in both ADDR and DATA, so same-cycle AR+R slaves are supported.
- Error rresp (≠0) is passed through unchanged and completes the transaction normally. No retry is issued by the arbiter.
- Fixed-priority arbitration (macro undefined): LSU (m1) wins whenever m1_arvalid=1.
- Minimum latency: request to s_arvalid is 1 cycle. Back-to-back grants are separated by 1 IDLE cycle.
- A request arriving while busy is held by its master (AXI rule) and is arbitrated in the next IDLE.
- Reset mid-transaction: all outputs go to reset values immediately. No response is delivered for the aborted read.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both masters request in IDLE, grant goes to the master ≠ last_grant. A single requester always wins.
- Undefined: fixed priority with m1 over m0. last_grant is still kept but unused.

Test Plan:
- IFU-only read, addr 0x80000000, slave arready after 2 cycles and rvalid 1 cycle later with rdata 0x00000413 -> m0_rdata=0x00000413, m0_rvalid is a single pulse, m1 sees no valid, state returns to IDLE.
- Simultaneous m0 0x80000004 and m1 0x80001000, fixed priority -> s_araddr=0x80001000 first, then 0x80000004 after 1 IDLE cycle. Each response goes only to its owner.
- Same simultaneous stimulus repeated 4 times with ARB_ROUND_ROBIN_EN -> grants alternate m0,m1,m0,m1; first tie goes to m0.
- Slave returns rresp=3'b010 for m1 -> m1_rresp=3'b010, transaction completes, a pending m0 request is served next.
- Same-cycle s_arready & s_rvalid with m0_rready=1 -> completes in ADDR, DATA is skipped, IDLE the next cycle.
- rst_n pulled low while in DATA -> all valids/readies 0 immediately, state IDLE, grant=0.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master (m0 IFU, m1 LSU) to one-slave AXI-lite read arbiter, one read in flight.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate against last_grant; default is fixed priority m1 > m0.
module axi_rd_arbiter #(
   parameter int DATA_LEN = 32,
   parameter int RESP_LEN = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   input  logic [DATA_LEN-1:0] m0_araddr,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   output logic [DATA_LEN-1:0] m0_rdata,
   output logic [RESP_LEN-1:0] m0_rresp,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   input  logic [DATA_LEN-1:0] m1_araddr,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   output logic [DATA_LEN-1:0] m1_rdata,
   output logic [RESP_LEN-1:0] m1_rresp,
   output logic                s_arvalid,
   input  logic                s_arready,
   output logic [DATA_LEN-1:0] s_araddr,
   input  logic                s_rvalid,
   output logic                s_rready,
   input  logic [DATA_LEN-1:0] s_rdata,
   input  logic [RESP_LEN-1:0] s_rresp
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_ADDR = 2'b01;
   localparam logic [1:0] ST_DATA = 2'b11;

   logic [1:0]          state_r;
   logic [1:0]          next_state_s;
   logic                grant_r;
   logic                next_grant_s;
   logic                last_grant_r;
   logic                next_last_grant_s;
   logic                sel_arvalid_s;
   logic [DATA_LEN-1:0] sel_araddr_s;
   logic                sel_rready_s;
   logic                ar_hs_s;
   logic                r_hs_s;

   // Winner for a new grant; with no requester the pick parks on last_grant (result unused then).
   function automatic logic arb_pick(input logic req0, input logic req1, input logic last);
      logic pick;
`ifdef ARB_ROUND_ROBIN_EN
      if (req0 && req1) begin
         pick = ~last;
      end else if (req1) begin
         pick = 1'b1;
      end else if (req0) begin
         pick = 1'b0;
      end else begin
         pick = last;
      end
`else
      if (req1) begin
         pick = 1'b1;
      end else if (req0) begin
         pick = 1'b0;
      end else begin
         pick = last;
      end
`endif
      return pick;
   endfunction

   assign sel_arvalid_s = grant_r ? m1_arvalid : m0_arvalid;
   assign sel_araddr_s  = grant_r ? m1_araddr  : m0_araddr;
   assign sel_rready_s  = grant_r ? m1_rready  : m0_rready;
   assign ar_hs_s       = sel_arvalid_s & s_arready;
   assign r_hs_s        = s_rvalid & sel_rready_s;

   // Read data and response fan out to both masters; only the owner sees rvalid.
   assign m0_rdata = s_rdata;
   assign m1_rdata = s_rdata;
   assign m0_rresp = s_rresp;
   assign m1_rresp = s_rresp;

   // State, grant and last-grant registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         grant_r      <= 1'b0;
         last_grant_r <= 1'b1;
      end else begin
         state_r      <= next_state_s;
         grant_r      <= next_grant_s;
         last_grant_r <= next_last_grant_s;
      end
   end

   // Next-state, grant latch and last-grant update.
   always_comb begin
      next_state_s      = state_r;
      next_grant_s      = grant_r;
      next_last_grant_s = last_grant_r;
      case (state_r)
         ST_IDLE: begin
            if (m0_arvalid || m1_arvalid) begin
               next_grant_s = arb_pick(m0_arvalid, m1_arvalid, last_grant_r);
               next_state_s = ST_ADDR;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (ar_hs_s) begin
               // Same-cycle AR and R acceptance finishes without visiting DATA.
               if (r_hs_s) begin
                  next_state_s      = ST_IDLE;
                  next_last_grant_s = grant_r;
               end else begin
                  next_state_s = ST_DATA;
               end
            end else if (!sel_arvalid_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (r_hs_s) begin
               next_state_s      = ST_IDLE;
               next_last_grant_s = grant_r;
            end else begin
               next_state_s = ST_DATA;
            end
         end
         default: begin
            next_state_s      = ST_IDLE;
            next_grant_s      = 1'b0;
            next_last_grant_s = 1'b1;
         end
      endcase
   end

   // Channel muxing toward the slave and handshake routing back to the owner.
   always_comb begin
      s_arvalid  = 1'b0;
      s_araddr   = {DATA_LEN{1'b0}};
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      case (state_r)
         ST_ADDR: begin
            s_arvalid = sel_arvalid_s;
            s_araddr  = sel_araddr_s;
            s_rready  = sel_rready_s;
            if (grant_r) begin
               m1_arready = s_arready;
               m1_rvalid  = s_rvalid;
            end else begin
               m0_arready = s_arready;
               m0_rvalid  = s_rvalid;
            end
         end
         ST_DATA: begin
            s_rready = sel_rready_s;
            if (grant_r) begin
               m1_rvalid = s_rvalid;
            end else begin
               m0_rvalid = s_rvalid;
            end
         end
         default: begin
            s_arvalid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected slave addresses and per-master responses are queued
// at issue time and a negedge monitor pops/compares them on every handshake.
module tb_axi_rd_arbiter;

   typedef struct {
      logic [31:0] d;
      logic [2:0]  r;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic [31:0] m0_araddr, m0_rdata;
   logic [2:0]  m0_rresp;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic [31:0] m1_araddr, m1_rdata;
   logic [2:0]  m1_rresp;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic [31:0] s_araddr, s_rdata;
   logic [2:0]  s_rresp;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] req0[$];
   logic [31:0] req1[$];
   logic [31:0] exp_addr[$];
   rsp_t        exp0[$];
   rsp_t        exp1[$];
   logic        busy0 = 1'b0;
   logic        busy1 = 1'b0;
   logic        saw_data = 1'b0;

   int   ar_wait = 2;
   int   r_wait = 0;
   logic same_cycle = 1'b0;

   axi_rd_arbiter #(.DATA_LEN(32), .RESP_LEN(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic logic [31:0] slv_data(input logic [31:0] a);
      case (a)
         32'h8000_0000: return 32'h0000_0413;
         32'h8000_0004: return 32'h0010_0093;
         32'h8000_1000: return 32'hdead_beef;
         32'h8000_1004: return 32'h1234_5678;
         32'h8000_1008: return 32'hcafe_f00d;
         default:       return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [2:0] slv_resp(input logic [31:0] a);
      return (a == 32'h8000_1008) ? 3'b010 : 3'b000;
   endfunction

   // SRAM slave model: sample at negedge (values valid for the next edge), drive 1 time unit after posedge.
   initial begin : slave
      int cnt;
      int st;
      logic arv, hs_ar, hs_r;
      logic [31:0] cur_addr;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h5a5a_0001; s_rresp = 3'b001;
      st = 0; cnt = 0; cur_addr = 32'h0;
      forever begin
         @(negedge clk);
         arv   = s_arvalid;
         hs_ar = s_arvalid & s_arready;
         hs_r  = s_rvalid & s_rready;
         if (hs_ar) cur_addr = s_araddr;
         @(posedge clk); #1;
         if (!rst_n) begin
            s_arready = 1'b0; s_rvalid = 1'b0; st = 0; cnt = 0;
         end else begin
            case (st)
               0: if (arv) begin
                  if (cnt >= ar_wait) begin
                     s_arready = 1'b1;
                     if (same_cycle) begin
                        s_rvalid = 1'b1; s_rdata = slv_data(s_araddr); s_rresp = slv_resp(s_araddr);
                     end
                     st = 1;
                  end else cnt++;
               end
               1: if (hs_ar) begin
                  s_arready = 1'b0; cnt = 0;
                  if (same_cycle) begin
                     if (hs_r) begin s_rvalid = 1'b0; st = 0; end
                     else st = 3;
                  end else st = 2;
               end
               2: if (cnt >= r_wait) begin
                  s_rvalid = 1'b1; s_rdata = slv_data(cur_addr); s_rresp = slv_resp(cur_addr); st = 3;
               end else cnt++;
               3: if (hs_r) begin s_rvalid = 1'b0; st = 0; cnt = 0; end
               default: st = 0;
            endcase
         end
      end
   end

   // Master 0 driver: hold arvalid until accepted (bounded).
   initial begin : m0_drv
      logic hs;
      int budget;
      m0_arvalid = 1'b0; m0_araddr = 32'h0; m0_rready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rst_n && req0.size() != 0) begin
            busy0 = 1'b1; m0_araddr = req0.pop_front(); m0_arvalid = 1'b1;
            hs = 1'b0; budget = 0;
            while (!hs && budget < 200) begin
               @(negedge clk); hs = m0_arvalid & m0_arready;
               @(posedge clk); #1; budget++;
            end
            m0_arvalid = 1'b0;
            if (!hs) fail_now("m0_ar_timeout");
            busy0 = 1'b0;
         end
      end
   end

   // Master 1 driver: hold arvalid until accepted (bounded).
   initial begin : m1_drv
      logic hs;
      int budget;
      m1_arvalid = 1'b0; m1_araddr = 32'h0; m1_rready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rst_n && req1.size() != 0) begin
            busy1 = 1'b1; m1_araddr = req1.pop_front(); m1_arvalid = 1'b1;
            hs = 1'b0; budget = 0;
            while (!hs && budget < 200) begin
               @(negedge clk); hs = m1_arvalid & m1_arready;
               @(posedge clk); #1; budget++;
            end
            m1_arvalid = 1'b0;
            if (!hs) fail_now("m1_ar_timeout");
            busy1 = 1'b0;
         end
      end
   end

   // Monitor: pop and compare on every slave AR handshake and every master R handshake.
   initial begin : monitor
      rsp_t e;
      logic [31:0] ea;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (dut.state_r == 2'b11) saw_data = 1'b1;
            if (s_arvalid && s_arready) begin
               if (exp_addr.size() == 0) fail_now("unexpected_s_ar");
               else begin ea = exp_addr.pop_front(); check("s_araddr", s_araddr, ea); end
            end
            if (m0_rvalid && m0_rready) begin
               if (exp0.size() == 0) fail_now("unexpected_m0_rvalid");
               else begin
                  e = exp0.pop_front();
                  check("m0_rdata", m0_rdata, e.d);
                  check("m0_rresp", {29'd0, m0_rresp}, {29'd0, e.r});
               end
            end
            if (m1_rvalid && m1_rready) begin
               if (exp1.size() == 0) fail_now("unexpected_m1_rvalid");
               else begin
                  e = exp1.pop_front();
                  check("m1_rdata", m1_rdata, e.d);
                  check("m1_rresp", {29'd0, m1_rresp}, {29'd0, e.r});
               end
            end
            if (m0_rvalid && m1_rvalid) fail_now("both_rvalid");
         end
      end
   end

   task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d, input logic [2:0] r);
      rsp_t e;
      e.d = d; e.r = r;
      if (m == 0) begin req0.push_back(a); exp0.push_back(e); end
      else begin req1.push_back(a); exp1.push_back(e); end
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (t < 500 && !(req0.size() == 0 && req1.size() == 0 && !busy0 && !busy1 &&
             exp_addr.size() == 0 && exp0.size() == 0 && exp1.size() == 0 && dut.state_r == 2'b00)) begin
         @(negedge clk); t++;
      end
      if (t >= 500) fail_now(name);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int t;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      // Reset state
      check("rst_valids", {26'd0, m0_arready, m0_rvalid, m1_arready, m1_rvalid, s_arvalid, s_rready}, 32'h0);
      check("rst_s_araddr", s_araddr, 32'h0);
      check("rst_state", {30'd0, dut.state_r}, 32'h0);
      check("rst_grant", {31'd0, dut.grant_r}, 32'h0);
      check("rst_last_grant", {31'd0, dut.last_grant_r}, 32'h1);
      check("rst_m0_rdata_copy", m0_rdata, 32'h5a5a_0001);
      check("rst_m1_rresp_copy", {29'd0, m1_rresp}, 32'h1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // IFU-only read with 1-cycle arbitration bubble before s_arvalid
      exp_addr.push_back(32'h8000_0000);
      issue(0, 32'h8000_0000, 32'h0000_0413, 3'b000);
      @(negedge clk);
      check("t1_bubble_s_arvalid", {31'd0, s_arvalid}, 32'h0);
      @(negedge clk);
      check("t1_s_arvalid", {31'd0, s_arvalid}, 32'h1);
      check("t1_s_araddr_early", s_araddr, 32'h8000_0000);
      check("t1_m1_arready", {31'd0, m1_arready}, 32'h0);
      wait_idle("t1_timeout");
      check("t1_state_idle", {30'd0, dut.state_r}, 32'h0);

      // Simultaneous requests: m1 first (fixed priority; last_grant=m0 under round robin)
      exp_addr.push_back(32'h8000_1000);
      exp_addr.push_back(32'h8000_0004);
      issue(0, 32'h8000_0004, 32'h0010_0093, 3'b000);
      issue(1, 32'h8000_1000, 32'hdead_beef, 3'b000);
      wait_idle("t2_timeout");

      // Four repeated ties from reset
      do_reset();
      ar_wait = 0; r_wait = 1;
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_addr.push_back(32'h8000_0000);
         exp_addr.push_back(32'h8000_1004);
`else
         exp_addr.push_back(32'h8000_1004);
         exp_addr.push_back(32'h8000_0000);
`endif
         issue(0, 32'h8000_0000, 32'h0000_0413, 3'b000);
         issue(1, 32'h8000_1004, 32'h1234_5678, 3'b000);
         wait_idle("t3_timeout");
      end

      // Error response on m1, pending m0 served afterwards
      ar_wait = 1; r_wait = 1;
      exp_addr.push_back(32'h8000_1008);
      exp_addr.push_back(32'h8000_0004);
      issue(1, 32'h8000_1008, 32'hcafe_f00d, 3'b010);
      @(negedge clk);
      issue(0, 32'h8000_0004, 32'h0010_0093, 3'b000);
      wait_idle("t4_timeout");
      check("t4_last_grant", {31'd0, dut.last_grant_r}, 32'h0);

      // Same-cycle AR and R: DATA never entered
      ar_wait = 0; same_cycle = 1'b1; saw_data = 1'b0;
      exp_addr.push_back(32'h8000_0000);
      issue(0, 32'h8000_0000, 32'h0000_0413, 3'b000);
      wait_idle("t5_timeout");
      check("t5_skipped_data", {31'd0, saw_data}, 32'h0);
      same_cycle = 1'b0;

      // Reset while in DATA aborts the read
      r_wait = 6;
      exp_addr.push_back(32'h8000_1000);
      issue(1, 32'h8000_1000, 32'hdead_beef, 3'b000);
      t = 0;
      while (t < 100 && dut.state_r != 2'b11) begin @(negedge clk); t++; end
      if (t >= 100) fail_now("t6_no_data_state");
      rst_n = 1'b0;
      #1;
      check("t6_valids", {26'd0, m0_arready, m0_rvalid, m1_arready, m1_rvalid, s_arvalid, s_rready}, 32'h0);
      check("t6_state", {30'd0, dut.state_r}, 32'h0);
      check("t6_grant", {31'd0, dut.grant_r}, 32'h0);
      exp1.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      r_wait = 0;
      repeat (10) @(negedge clk);
      check("t6_state_after", {30'd0, dut.state_r}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
